// File: rtl/par_parameter.sv
//------------------------------------------------------------------------------
// Module      : par_parameter
// Description : Shared operand-width package for the MAC and its inverse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package par_parameter;
    localparam int par = 7;
endpackage

`default_nettype wire

// File: rtl/mac_divider_if.sv
//------------------------------------------------------------------------------
// Module      : mac_divider_if
// Description : Operand/result handshake bundle for mac_divider.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mac_divider_if #(
    parameter int W = par_parameter::par + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   N;
    logic [W-1:0]     B;
    logic [W-1:0]     C;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     Q;
    logic [W-1:0]     R;
    logic             err_div0;
    logic             err_under;
    logic             err_ovf;

    modport master (
        output in_valid, N, B, C, out_ready,
        input  in_ready, out_valid, Q, R, err_div0, err_under, err_ovf
    );

    modport slave (
        input  in_valid, N, B, C, out_ready,
        output in_ready, out_valid, Q, R, err_div0, err_under, err_ovf
    );
endinterface

`default_nettype wire

// File: rtl/mac_divider.sv
//------------------------------------------------------------------------------
// Module      : mac_divider
// Description : Recovers A = (N - C) / B and remainder, one quotient bit per
//               clock. Optional macro MAC_DIVIDER_FAST_ERR_EN shortens errored ops.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_divider #(
    parameter int PAR = par_parameter::par
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mac_divider_if.slave    bus
);
    localparam int W  = PAR + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  n_q, n_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    c_q, c_d;
    // Partial remainder is always < B after each step, so W bits suffice.
    logic [W-1:0]    p_q, p_d;
    logic [W-1:0]    s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div0_q, div0_d;
    logic            under_q, under_d;
    logic            ovf_q, ovf_d;

    logic [2*W:0]    diff;
    logic [W:0]      trial;
    logic [W:0]      trial_sub;
    logic            any_err;

    assign diff      = {1'b0, n_q} - {{(W+1){1'b0}}, c_q};
    assign trial     = {p_q, s_q[W-1]};
    assign trial_sub = trial - {1'b0, b_q};
    assign any_err   = div0_q | under_q | ovf_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        b_d     = b_q;
        c_d     = c_q;
        p_d     = p_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        under_d = under_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    n_d     = bus.N;
                    b_d     = bus.B;
                    c_d     = bus.C;
                    div0_d  = 1'b0;
                    under_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SUB;
                end
            end
            SUB: begin
                div0_d  = (b_q == '0);
                under_d = (b_q != '0) & diff[2*W];
                ovf_d   = (b_q != '0) & ~diff[2*W] & (diff[2*W-1:W] >= b_q);
                p_d     = diff[2*W-1:W];
                s_d     = diff[W-1:0];
                cnt_d   = CW'(W);
                state_d = DIV;
            end
            DIV: begin
`ifdef MAC_DIVIDER_FAST_ERR_EN
                // Flags land at the SUB exit edge, so the bail-out happens here.
                if (any_err) begin
                    state_d = DONE;
                end else
`endif
                begin
                    if (!trial_sub[W]) begin
                        p_d = trial_sub[W-1:0];
                        s_d = {s_q[W-2:0], 1'b1};
                    end else begin
                        p_d = trial[W-1:0];
                        s_d = {s_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
            under_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            under_q <= under_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.err_div0  = div0_q;
        bus.err_under = under_q;
        bus.err_ovf   = ovf_q;
        bus.Q         = '0;
        bus.R         = '0;
        if (state_q == DONE) begin
            if (any_err) begin
                bus.Q = '1;
            end else begin
                bus.Q = s_q;
                bus.R = p_q;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mac_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_mac_divider
// Description : Directed self-checking bench for mac_divider (W = 8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_divider;
    localparam int W = 8;
`ifdef MAC_DIVIDER_FAST_ERR_EN
    localparam int ERR_LAT = 2;
`else
    localparam int ERR_LAT = 9;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat;

    mac_divider_if #(.W(W)) bus();

    mac_divider #(.PAR(W-1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present operands at a negedge, wait for the accept edge, return at the next negedge.
    task automatic send(input logic [15:0] n, input logic [7:0] b, input logic [7:0] c,
                        input bit hold);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.N = n;
        bus.B = b;
        bus.C = c;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", 32'(k < 40), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!bus.out_valid && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                           input logic d0, input logic un, input logic ov);
        chk({tag, "_Q"}, 32'(bus.Q), 32'(q));
        chk({tag, "_R"}, 32'(bus.R), 32'(r));
        chk({tag, "_flags"}, 32'({bus.err_div0, bus.err_under, bus.err_ovf}),
            32'({d0, un, ov}));
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.N         = '0;
        bus.B         = '0;
        bus.C         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_res("rst", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal: 12305 / 100 = 123 r 5
        send(16'd12350, 8'd100, 8'd45, 1'b0);
        chk("nom_in_ready_busy", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        chk("nom_latency", 32'(lat), 32'd9);
        chk_res("nom", 8'd123, 8'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("nom_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("nom_idle_ready", 32'(bus.in_ready), 32'd1);

        // Round trip of A=200, B=255, C=17 through the MAC
        send(16'd51017, 8'd255, 8'd17, 1'b0);
        wait_out(lat);
        chk("rt_latency", 32'(lat), 32'd9);
        chk_res("rt", 8'd200, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        send(16'd500, 8'd0, 8'd0, 1'b0);
        wait_out(lat);
        chk("div0_latency", 32'(lat), 32'(ERR_LAT));
        chk_res("div0", 8'd255, 8'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        send(16'd100, 8'd5, 8'd200, 1'b0);
        wait_out(lat);
        chk("under_latency", 32'(lat), 32'(ERR_LAT));
        chk_res("under", 8'd255, 8'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        send(16'd65535, 8'd1, 8'd0, 1'b0);
        wait_out(lat);
        chk("ovf_latency", 32'(lat), 32'(ERR_LAT));
        chk_res("ovf", 8'd255, 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Backpressure: 980 / 7 = 140 r 0, held for 5 stalled cycles
        bus.out_ready = 1'b0;
        send(16'd1000, 8'd7, 8'd20, 1'b0);
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            chk_res("bp", 8'd140, 8'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        chk_res("bp_final", 8'd140, 8'd0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);

        // Reset during DIV iteration 4
        send(16'd12350, 8'd100, 8'd45, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_res("mrst", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        send(16'd12350, 8'd100, 8'd45, 1'b0);
        wait_out(lat);
        chk("mrst_next_latency", 32'(lat), 32'd9);
        chk_res("mrst_next", 8'd123, 8'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back with in_valid held: 29900 / 200 = 149 r 100 follows
        send(16'd12350, 8'd100, 8'd45, 1'b1);
        bus.N = 16'd30000;
        bus.B = 8'd200;
        bus.C = 8'd100;
        wait_out(lat);
        chk("b2b1_latency", 32'(lat), 32'd9);
        chk("b2b1_in_ready", 32'(bus.in_ready), 32'd0);
        chk_res("b2b1", 8'd123, 8'd5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_gap_valid", 32'(bus.out_valid), 32'd0);
        chk("b2b_gap_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b2_accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        chk("b2b2_latency", 32'(lat), 32'd9);
        chk_res("b2b2", 8'd149, 8'd100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
